// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_flag_stage
//  Description : Single-entry execute-stage output register with an
//                architectural {N,Z,C} flags register and branch-condition
//                evaluation. Valid/ready handshake on both sides, drains and
//                refills in the same cycle, synchronous flush, asynchronous
//                active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_flag_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        flag_update,
  input  logic [2:0]  branch_cond,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd_addr,
  output logic        out_reg_write,
  output logic        out_branch_taken,
  output logic [2:0]  flags
);

  // Condition-code encoding of branch_cond.
  localparam logic [2:0] c_cond_never  = 3'b000;
  localparam logic [2:0] c_cond_always = 3'b001;
  localparam logic [2:0] c_cond_eq     = 3'b010;  // Z
  localparam logic [2:0] c_cond_ne     = 3'b011;  // !Z
  localparam logic [2:0] c_cond_mi     = 3'b100;  // N
  localparam logic [2:0] c_cond_gt     = 3'b101;  // !N & !Z
  localparam logic [2:0] c_cond_cs     = 3'b110;  // C
  localparam logic [2:0] c_cond_cc     = 3'b111;  // !C

  // Registered state.
  logic        out_valid_q,        out_valid_d;
  logic [31:0] out_result_q,       out_result_d;
  logic [4:0]  out_rd_addr_q,      out_rd_addr_d;
  logic        out_reg_write_q,    out_reg_write_d;
  logic        out_branch_taken_q, out_branch_taken_d;
  logic [2:0]  flags_q,            flags_d;

  // Combinational helpers.
  logic [2:0]  w_eval_flags;
  logic        w_n;
  logic        w_z;
  logic        w_c;
  logic        w_taken;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_drain;

  // Pick the flag source: an op that writes the flags sees its own result,
  // otherwise the branch looks at the architectural register.
  always_comb begin
    w_eval_flags = flag_update ? {alu_negative, alu_zero, alu_carry} : flags_q;
    w_n          = w_eval_flags[2];
    w_z          = w_eval_flags[1];
    w_c          = w_eval_flags[0];
    w_taken      = 1'b0;
    case (branch_cond)
      c_cond_never:  w_taken = 1'b0;
      c_cond_always: w_taken = 1'b1;
      c_cond_eq:     w_taken = w_z;
      c_cond_ne:     w_taken = ~w_z;
      c_cond_mi:     w_taken = w_n;
      c_cond_gt:     w_taken = ~w_n & ~w_z;
      c_cond_cs:     w_taken = w_c;
      c_cond_cc:     w_taken = ~w_c;
    endcase
  end

  // Handshake: single entry, so space exists when empty or when draining.
  always_comb begin
    w_in_ready = ~out_valid_q | out_ready;
    w_accept   = in_valid & w_in_ready & ~flush;
    w_drain    = out_valid_q & out_ready;
  end

  // Next-state: flush dominates, then accept (which also covers a
  // simultaneous drain, giving back-to-back throughput), then plain drain.
  always_comb begin
    out_valid_d        = out_valid_q;
    out_result_d       = out_result_q;
    out_rd_addr_d      = out_rd_addr_q;
    out_reg_write_d    = out_reg_write_q;
    out_branch_taken_d = out_branch_taken_q;
    flags_d            = flags_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d        = 1'b1;
      out_result_d       = alu_result;
      out_rd_addr_d      = rd_addr;
      out_reg_write_d    = reg_write;
      out_branch_taken_d = w_taken;
      if (flag_update) begin
        flags_d = {alu_negative, alu_zero, alu_carry};
      end
    end else if (w_drain) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q        <= 1'b0;
      out_result_q       <= 32'd0;
      out_rd_addr_q      <= 5'd0;
      out_reg_write_q    <= 1'b0;
      out_branch_taken_q <= 1'b0;
      flags_q            <= 3'b000;
    end else begin
      out_valid_q        <= out_valid_d;
      out_result_q       <= out_result_d;
      out_rd_addr_q      <= out_rd_addr_d;
      out_reg_write_q    <= out_reg_write_d;
      out_branch_taken_q <= out_branch_taken_d;
      flags_q            <= flags_d;
    end
  end

  // Side-effect qualifiers are gated so a stale entry can never write back
  // or redirect the PC.
  always_comb begin
    in_ready         = w_in_ready;
    out_valid        = out_valid_q;
    out_result       = out_result_q;
    out_rd_addr      = out_rd_addr_q;
    out_reg_write    = out_valid_q & out_reg_write_q;
    out_branch_taken = out_valid_q & out_branch_taken_q;
    flags            = flags_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_flag_stage
//  Description : Self-checking bench for ex_flag_stage. A negedge monitor
//                keeps a reference model (scoreboard queue + flags) and
//                compares every cycle; scenario tasks add directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_flag_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_carry;
  logic        flag_update;
  logic [2:0]  branch_cond;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic        out_branch_taken;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        tk;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] m_flags;

  ex_flag_stage dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_result       (alu_result),
    .alu_negative     (alu_negative),
    .alu_zero         (alu_zero),
    .alu_carry        (alu_carry),
    .flag_update      (flag_update),
    .branch_cond      (branch_cond),
    .rd_addr          (rd_addr),
    .reg_write        (reg_write),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd_addr      (out_rd_addr),
    .out_reg_write    (out_reg_write),
    .out_branch_taken (out_branch_taken),
    .flags            (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference branch decision from the condition-code table.
  function automatic logic cond_model(input logic [2:0] bc, input logic [2:0] f);
    logic n, z, c;
    n = f[2]; z = f[1]; c = f[0];
    case (bc)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return n;
      3'd5: return (!n) && (!z);
      3'd6: return c;
      default: return !c;
    endcase
  endfunction

  // Scoreboard monitor: check against the model, then advance the model
  // for the coming rising edge. Inputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic m_ready;
    logic acc;
    logic [2:0] eff;
    if (!rst) begin
      n_checks++;
      if (out_valid !== 1'b0 || flags !== 3'b000 || in_ready !== 1'b1 || out_result !== 32'd0 ||
          out_rd_addr !== 5'd0 || out_reg_write !== 1'b0 || out_branch_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL mon_reset: valid=%b flags=%b rdy=%b res=%h rd=%0d rw=%b tk=%b, required all zero with rdy=1",
                 out_valid, flags, in_ready, out_result, out_rd_addr, out_reg_write, out_branch_taken);
      end
      sb_q.delete();
      m_flags = 3'b000;
    end else begin
      n_checks++;
      if (out_valid !== (sb_q.size() != 0)) begin
        n_fail++;
        $display("FAIL mon_valid: got %b, required %b", out_valid, sb_q.size() != 0);
      end
      n_checks++;
      if (flags !== m_flags) begin
        n_fail++;
        $display("FAIL mon_flags: got %b, required %b", flags, m_flags);
      end
      m_ready = (sb_q.size() == 0) || out_ready;
      n_checks++;
      if (in_ready !== m_ready) begin
        n_fail++;
        $display("FAIL mon_in_ready: got %b, required %b", in_ready, m_ready);
      end
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        n_checks++;
        if (out_result !== e.res || out_rd_addr !== e.rd || out_reg_write !== e.rw || out_branch_taken !== e.tk) begin
          n_fail++;
          $display("FAIL mon_entry: got res=%h rd=%0d rw=%b tk=%b, required res=%h rd=%0d rw=%b tk=%b",
                   out_result, out_rd_addr, out_reg_write, out_branch_taken, e.res, e.rd, e.rw, e.tk);
        end
      end else begin
        n_checks++;
        if (out_reg_write !== 1'b0 || out_branch_taken !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_idle_gating: got rw=%b tk=%b, required 0 0", out_reg_write, out_branch_taken);
        end
      end
      acc = in_valid && m_ready && !flush;
      if (flush) sb_q.delete();
      else if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (acc) begin
        eff   = flag_update ? {alu_negative, alu_zero, alu_carry} : m_flags;
        e.res = alu_result;
        e.rd  = rd_addr;
        e.rw  = reg_write;
        e.tk  = cond_model(branch_cond, eff);
        sb_q.push_back(e);
        if (flag_update) m_flags = eff;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; flag_update = 1'b0;
    alu_negative = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    alu_result = 32'd0; branch_cond = 3'd0; rd_addr = 5'd0; reg_write = 1'b0;
  endtask

  task automatic drive_op(input logic [31:0] res, input logic [2:0] nzc, input logic fu,
                          input logic [2:0] bc, input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; flush = 1'b0;
    alu_result = res; {alu_negative, alu_zero, alu_carry} = nzc;
    flag_update = fu; branch_cond = bc; rd_addr = rd; reg_write = rw;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; idle();
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || flags !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b flags=%b rdy=%b, required 0 000 1", out_valid, flags, in_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_branch();
    drive_op(32'd0, 3'b010, 1'b1, 3'b010, 5'd3, 1'b1);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || out_branch_taken !== 1'b1 || flags !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_branch: valid=%b tk=%b flags=%b, required 1 1 010", out_valid, out_branch_taken, flags);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_op(32'hA5A5_0001, 3'b100, 1'b1, 3'b100, 5'd7, 1'b1);
    tick();
    drive_op(32'hB0B0_0002, 3'b010, 1'b1, 3'b011, 5'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_result !== 32'hA5A5_0001 || flags !== 3'b100) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: rdy=%b res=%h flags=%b, required 0 a5a50001 100", i, in_ready, out_result, flags);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b, required 1", in_ready);
    end
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hB0B0_0002 || flags !== 3'b010 || out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_next_op: valid=%b res=%h flags=%b tk=%b, required 1 b0b00002 010 0",
               out_valid, out_result, flags, out_branch_taken);
    end
    tick();
  endtask

  task automatic test_stored_flag();
    drive_op(32'h0000_00AA, 3'b001, 1'b1, 3'b000, 5'd1, 1'b1);
    tick();
    drive_op(32'h0000_00BB, 3'b000, 1'b0, 3'b110, 5'd2, 1'b1);
    tick();
    idle();
    n_checks++;
    if (out_result !== 32'h0000_00BB || out_branch_taken !== 1'b1 || flags !== 3'b001) begin
      n_fail++;
      $display("FAIL stored_carry: res=%h tk=%b flags=%b, required bb 1 001", out_result, out_branch_taken, flags);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_op(32'(i), 3'b000, 1'b0, 3'b001, 5'(i), 1'b1);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'(i)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: valid=%b res=%0d, required 1 %0d", i, out_valid, out_result, i);
      end
    end
    idle();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(32'h0000_0C0C, 3'b000, 1'b0, 3'b001, 5'd4, 1'b1);
    tick();
    drive_op(32'h0000_0D0D, 3'b100, 1'b1, 3'b100, 5'd5, 1'b1);
    flush = 1'b1;
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b0 || flags !== 3'b001 || out_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: valid=%b flags=%b rw=%b, required 0 001 0", out_valid, flags, out_reg_write);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive_op($urandom, 3'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_op(32'hDEAD_BEEF, 3'b111, 1'b1, 3'b001, 5'd31, 1'b1);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || flags !== 3'b111) begin
      n_fail++;
      $display("FAIL async_setup: valid=%b flags=%b, required 1 111", out_valid, flags);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || flags !== 3'b000 || out_result !== 32'd0 || out_rd_addr !== 5'd0 ||
        out_reg_write !== 1'b0 || out_branch_taken !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b flags=%b res=%h rd=%0d rw=%b tk=%b rdy=%b, required zeros with rdy=1",
               out_valid, flags, out_result, out_rd_addr, out_reg_write, out_branch_taken, in_ready);
    end
    #3 rst = 1'b1;
    out_ready = 1'b1;
    tick();
    drive_op(32'h0000_1234, 3'b000, 1'b0, 3'b011, 5'd6, 1'b1);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_1234 || out_branch_taken !== 1'b1 || flags !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_accept: valid=%b res=%h tk=%b flags=%b, required 1 1234 1 000",
               out_valid, out_result, out_branch_taken, flags);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_zero_branch();
    test_backpressure();
    test_stored_flag();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 The block SHALL have exactly one clock, `clk`; all state SHALL update on its rising edge.
REQ-002 The block SHALL take reset on `rst`; reset is asynchronous and active-low, and it forces every register to its reset value immediately, independent of `clk`.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 in_valid  input  1  upstream ALU result is valid this cycle.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 alu_result  input  32  ALU output word.
REQ-009 alu_negative, alu_zero, alu_carry  input  1 each  ALU flags.
REQ-010 flag_update  input  1  this op writes the flags register.
REQ-011 branch_cond  input  3  condition code (REQ-019).
REQ-012 rd_addr  input  5  destination register.
REQ-013 reg_write  input  1  op writes the register file.
REQ-014 out_valid  output  1  output register holds a valid op.
REQ-015 out_ready  input  1  downstream (writeback/PC) accepts.
REQ-016 out_result  output  32  latched ALU result.
REQ-017 out_rd_addr  output  5; out_reg_write  output  1; out_branch_taken  output  1  latched with the result.
REQ-018 flags  output  3  architectural {N,Z,C} register, bit 2 = N.

Function
REQ-019 branch_cond encoding SHALL be: 000 never, 001 always, 010 Z, 011 !Z, 100 N, 101 !N&!Z, 110 C, 111 !C.
REQ-020 The condition SHALL evaluate the incoming alu_* flags when flag_update=1, and the stored flags register otherwise.
REQ-021 in_ready SHALL equal !out_valid | out_ready (combinational, single-entry stage).
REQ-022 Accept SHALL occur when in_valid & in_ready & !flush.
REQ-023 On accept, the output register SHALL load alu_result, rd_addr, reg_write and the evaluated branch_taken, and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-024 On accept with flag_update=1, flags SHALL load {alu_negative, alu_zero, alu_carry} in the same edge; otherwise flags SHALL hold.
REQ-025 When out_valid=1 & out_ready=0, every out_* field SHALL be held stable and in_ready SHALL be 0.
REQ-026 When out_valid=1 & out_ready=1 with no accept, out_valid SHALL go to 0 on the next edge.
REQ-027 Output drain and new accept in the same cycle SHALL replace the entry with no bubble, sustaining 1 op/cycle.
REQ-028 flush=1 SHALL clear out_valid on the next edge, block accept, and leave flags unchanged, even if in_valid=1 and flag_update=1.
REQ-029 out_reg_write and out_branch_taken SHALL be meaningful only while out_valid=1; while out_valid=0 both SHALL be forced to 0.
REQ-030 in_valid=0 SHALL never alter any register except through REQ-026 and REQ-028.

Reset
REQ-031 While rst=0: out_valid=0, out_result=0, out_rd_addr=0, out_reg_write=0, out_branch_taken=0, flags=3'b000, and in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL discard the held entry with no partial flag update; the first accept after rst rises SHALL behave as from idle.

Verification
REQ-033 After reset, in_valid=1, alu_result=0, alu_zero=1, flag_update=1, branch_cond=010 -> next cycle out_valid=1, out_branch_taken=1, flags=3'b010.
REQ-034 out_ready=0 with an entry held, new in_valid=1 -> in_ready=0, out_result unchanged for 5 cycles, flags unchanged; out_ready=1 -> new op appears one cycle later.
REQ-035 Op A sets C=1 (flag_update=1); op B has flag_update=0, branch_cond=110, alu_carry=0 -> B gets out_branch_taken=1 from stored C.
REQ-036 Back-to-back accepts with out_ready=1 for 8 cycles, results 1..8 -> out_result sequence 1..8 on consecutive cycles, no bubbles.
REQ-037 flush=1 coincident with in_valid=1, flag_update=1, alu_negative=1 -> next cycle out_valid=0, flags unchanged.
REQ-038 rst pulsed low between clock edges while out_valid=1, flags=3'b111 -> outputs and flags read 0 before the next rising edge.
